// File: rtl/access_ctrl_pkg.sv
// Shared encodings and banner contents for the access-control demo.
package access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } seq_state_t;

  localparam int MSG_LEN = 16;

  // "ACCESS CONTROL\r\n"
  localparam logic [7:0] MSG_ROM [MSG_LEN] = '{
    8'h41, 8'h43, 8'h43, 8'h45, 8'h53, 8'h53, 8'h20, 8'h43,
    8'h4F, 8'h4E, 8'h54, 8'h52, 8'h4F, 8'h4C, 8'h0D, 8'h0A
  };

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/access_control_system_uart_tx.sv
// Baud-rate UART transmitter, 8N1; UART_PARITY_EN adds an even-parity bit (8E1).
module uart_tx
  import access_ctrl_pkg::*;
#(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       txd
);

  localparam int DIV   = clk_freq / uart_baud_rate;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic [CNT_W-1:0]      r_baud_cnt;
  logic [3:0]            r_bits_left;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_active;
  logic                  r_txd;
  logic [FRAME_BITS-1:0] w_frame;
  logic                  w_last_tick;

`ifdef UART_PARITY_EN
  assign w_frame = {1'b1, even_parity(tx_data), tx_data, 1'b0};
`else
  assign w_frame = {1'b1, tx_data, 1'b0};
`endif

  // Busy drops for the final clock of the stop bit so a request issued then
  // lands one clock after the stop bit ends.
  assign w_last_tick = (r_bits_left == 4'd0) && (r_baud_cnt == '0);
  assign tx_busy     = r_active && !w_last_tick;
  assign txd         = r_txd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud_cnt  <= '0;
      r_bits_left <= 4'd0;
      r_shift     <= '0;
      r_active    <= 1'b0;
      r_txd       <= 1'b1;
    end else if (tx_start && !tx_busy) begin
      r_txd       <= w_frame[0];
      r_shift     <= w_frame >> 1;
      r_bits_left <= 4'(FRAME_BITS - 1);
      r_baud_cnt  <= CNT_W'(DIV - 1);
      r_active    <= 1'b1;
    end else if (r_active) begin
      if (r_baud_cnt != '0) begin
        r_baud_cnt <= r_baud_cnt - CNT_W'(1);
      end else if (r_bits_left == 4'd0) begin
        r_active <= 1'b0;
      end else begin
        r_txd       <= r_shift[0];
        r_shift     <= r_shift >> 1;
        r_bits_left <= r_bits_left - 4'd1;
        r_baud_cnt  <= CNT_W'(DIV - 1);
      end
    end
  end

endmodule

// File: rtl/access_control_system.sv
// Repeats the "ACCESS CONTROL\r\n" banner on UartTx and mirrors the byte on leds.
// UART_PARITY_EN (default undefined) switches the transmitter to 8E1 frames.
//   state | meaning
//   IDLE  | just out of reset, issue first request
//   SEND  | tx_start high for one clock, leds load the byte
//   WAIT  | frame in flight, advance index when transmitter frees
//   GAP   | idle line between banner repetitions
module access_control_system
  import access_ctrl_pkg::*;
#(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 9600,
  parameter int gap_bits       = 10
) (
  input  logic       clk,
  input  logic       rst,
  output logic       UartTx,
  output logic [7:0] leds
);

  localparam int DIV      = clk_freq / uart_baud_rate;
  localparam int GAP_CLKS = gap_bits * DIV;
  localparam int GAP_W    = $clog2(GAP_CLKS + 1);

  seq_state_t       r_state;
  logic [3:0]       r_index;
  logic             r_tx_start;
  logic [7:0]       r_leds;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             w_tx_busy;
  logic [7:0]       w_tx_data;
  logic             w_txd;

  assign w_tx_data = MSG_ROM[r_index];
  assign leds      = r_leds;
  assign UartTx    = w_txd;

  uart_tx #(
    .clk_freq      (clk_freq),
    .uart_baud_rate(uart_baud_rate)
  ) u_uart_tx (
    .clk     (clk),
    .rst     (rst),
    .tx_start(r_tx_start),
    .tx_data (w_tx_data),
    .tx_busy (w_tx_busy),
    .txd     (w_txd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_index    <= 4'd0;
      r_tx_start <= 1'b0;
      r_leds     <= 8'h00;
      r_gap_cnt  <= '0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx_start <= 1'b1;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          // The transmitter accepts on this same edge, so the start bit and leds align.
          r_leds  <= w_tx_data;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!w_tx_busy) begin
            if (r_index == 4'(MSG_LEN - 1)) begin
              r_index   <= 4'd0;
              r_gap_cnt <= GAP_W'(GAP_CLKS - 1);
              r_state   <= ST_GAP;
            end else begin
              r_index    <= r_index + 4'd1;
              r_tx_start <= 1'b1;
              r_state    <= ST_SEND;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) begin
            r_tx_start <= 1'b1;
            r_state    <= ST_SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_access_control_system.sv
// Directed bench for access_control_system at a shortened bit period (DIV=8).
`timescale 1ns/1ps
module tb_access_control_system;

  localparam int CLK_FREQ = 80;
  localparam int BAUD     = 10;
  localparam int GAP_BITS = 10;
  localparam int DIV      = 8;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int PERIOD     = FRAME_BITS * DIV + 1;
  localparam int GAP_PERIOD = FRAME_BITS * DIV + GAP_BITS * DIV + 1;
  localparam int TMO        = 2 * GAP_PERIOD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       UartTx;
  logic [7:0] leds;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_mis = 0;

  logic [7:0] exp_msg [16] = '{
    8'h41, 8'h43, 8'h43, 8'h45, 8'h53, 8'h53, 8'h20, 8'h43,
    8'h4F, 8'h4E, 8'h54, 8'h52, 8'h4F, 8'h4C, 8'h0D, 8'h0A
  };

  access_control_system #(
    .clk_freq      (CLK_FREQ),
    .uart_baud_rate(BAUD),
    .gap_bits      (GAP_BITS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .UartTx(UartTx),
    .leds  (leds)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns the edge count at which the line was first seen low.
  task automatic wait_start(output int t);
    int k;
    k = 0;
    t = -1;
    while (k < TMO && t < 0) begin
      @(negedge clk);
      if (UartTx === 1'b0) t = cyc;
      k++;
    end
    if (t < 0) begin
      check("start_seen", UartTx, 0);
      t = cyc;
    end
  endtask

  // Called half a clock into the start bit; samples every bit at mid-period.
  task automatic rx_frame(output logic [FRAME_BITS-1:0] bits);
    repeat (DIV / 2) @(negedge clk);
    bits[0] = UartTx;
    for (int b = 1; b < FRAME_BITS; b++) begin
      repeat (DIV) @(negedge clk);
      bits[b] = UartTx;
    end
  endtask

  task automatic check_frame(input string tag, input logic [FRAME_BITS-1:0] bits,
                             input logic [7:0] exp);
    check({tag, "_start"}, bits[0], 0);
    check({tag, "_data"}, bits[8:1], exp);
`ifdef UART_PARITY_EN
    check({tag, "_par"}, bits[9], ^exp);
`endif
    check({tag, "_stop"}, bits[FRAME_BITS-1], 1);
  endtask

  initial begin
    int t_prev;
    int t;
    int rel;
    logic [FRAME_BITS-1:0] bits;
    logic [FRAME_BITS-1:0] a_bits;
`ifdef UART_PARITY_EN
    a_bits = 11'b1_0_01000001_0;
`else
    a_bits = 10'b1_01000001_0;
`endif

    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_txd", UartTx, 1);
      check("rst_leds", leds, 8'h00);
    end

    @(negedge clk);
    rst = 1'b1;
    rel = cyc;
    @(negedge clk);
    check("edge1_txd", UartTx, 1);
    wait_start(t);
    check("start_lat", t - rel, 2);
    check("first_leds", leds, 8'h41);
    rx_frame(bits);
    for (int b = 0; b < FRAME_BITS; b++)
      check($sformatf("a_bit%0d", b), bits[b], a_bits[b]);

    t_prev = t;
    for (int i = 1; i < 16; i++) begin
      wait_start(t);
      check($sformatf("per%0d", i), t - t_prev, PERIOD);
      check($sformatf("leds%0d", i), leds, exp_msg[i]);
      rx_frame(bits);
      check_frame($sformatf("byte%0d", i), bits, exp_msg[i]);
      t_prev = t;
    end

    wait_start(t);
    check("gap_per", t - t_prev, GAP_PERIOD);
    check("wrap_leds", leds, 8'h41);
    rx_frame(bits);
    check_frame("wrap", bits, 8'h41);
    t_prev = t;

    wait_start(t);
    check("c_per", t - t_prev, PERIOD);
    check("c_leds", leds, 8'h43);
    repeat (5 * DIV + DIV / 2) @(negedge clk);
    check("pre_rst_line", UartTx, 0);
    rst = 1'b0;
    #1;
    check("mid_rst_txd", UartTx, 1);
    check("mid_rst_leds", leds, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_hold_txd", UartTx, 1);
    check("rst_hold_leds", leds, 8'h00);
    rst = 1'b1;
    rel = cyc;
    wait_start(t);
    check("restart_lat", t - rel, 2);
    check("restart_leds", leds, 8'h41);
    rx_frame(bits);
    check_frame("restart", bits, 8'h41);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
